// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding and
// small helpers used by the datapath.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Saturating-counter helper: true when a counter of the given width is all ones.
    function automatic logic is_all_ones(input logic [31:0] value, input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return ((value & mask) == mask);
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Turns one-cycle trigger pulses into fixed-length high levels separated by
// a mandatory low gap, with a saturating queue or retrigger for busy pulses.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned PEND_W      = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_pulse,
    input  logic              retrig,
    input  logic              clr_ovf,
    output logic              out_level,
    output logic              done,
    output logic              busy,
    output logic [PEND_W-1:0] pend_count,
    output logic              overflow
);

    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic [PEND_W-1:0] pend_r;
    logic [PEND_W-1:0] pend_s;
    logic              ovf_r;
    logic              ovf_s;
    logic              out_level_r;
    logic              done_r;
    logic              done_s;
    logic              busy_r;
    logic              enq_s;
    logic              deq_s;
    logic              drop_s;
    logic              pend_full_s;

    assign pend_full_s = is_all_ones(32'(pend_r), PEND_W);

    // Next-state, shared hold/gap counter and queue-request decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        done_s  = 1'b0;
        enq_s   = 1'b0;
        deq_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_pulse) begin
                    state_s = ST_HOLD;
                    cnt_s   = HOLD_LOAD;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            ST_HOLD: begin
                if (in_pulse && retrig) begin
                    // Retrigger supersedes the current hold, so no done for it.
                    cnt_s = HOLD_LOAD;
                end else if (cnt_r == CNT_ZERO) begin
                    state_s = ST_GAP;
                    cnt_s   = GAP_LOAD;
                    done_s  = 1'b1;
                    enq_s   = in_pulse;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                    enq_s   = in_pulse;
                end
            end
            ST_GAP: begin
                if (cnt_r == CNT_ZERO) begin
                    if (pend_r != PEND_ZERO) begin
                        state_s = ST_HOLD;
                        cnt_s   = HOLD_LOAD;
                        deq_s   = 1'b1;
                        enq_s   = in_pulse;
                    end else if (in_pulse) begin
                        // Empty queue: the arriving pulse is served directly.
                        state_s = ST_HOLD;
                        cnt_s   = HOLD_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = CNT_ZERO;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                    enq_s = in_pulse;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Saturating pending counter and sticky overflow (set beats clear).
    always_comb begin
        pend_s = pend_r;
        drop_s = 1'b0;
        case ({enq_s, deq_s})
            2'b10: begin
                if (pend_full_s) begin
                    drop_s = 1'b1;
                end else begin
                    pend_s = pend_r + PEND_ONE;
                end
            end
            2'b01: begin
                pend_s = pend_r - PEND_ONE;
            end
            default: begin
                pend_s = pend_r;
            end
        endcase
        if (drop_s) begin
            ovf_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_s = 1'b0;
        end else begin
            ovf_s = ovf_r;
        end
    end

    // State, counter and registered output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            pend_r      <= PEND_ZERO;
            ovf_r       <= 1'b0;
            out_level_r <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            pend_r      <= pend_s;
            ovf_r       <= ovf_s;
            out_level_r <= (state_s == ST_HOLD);
            done_r      <= done_s;
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign out_level  = out_level_r;
    assign done       = done_r;
    assign busy       = busy_r;
    assign pend_count = pend_r;
    assign overflow   = ovf_r;

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench for pulse_stretch (HOLD=4, GAP=2, PEND_W=2); expected
// per-cycle outputs are queued as stimulus is driven and compared after each edge.
module tb_pulse_stretch;

    typedef logic [5:0] obs_t;  // {out_level, done, busy, pend_count[1:0], overflow}

    logic       clk;
    logic       rst;
    logic       in_pulse;
    logic       retrig;
    logic       clr_ovf;
    logic       out_level;
    logic       done;
    logic       busy;
    logic [1:0] pend_count;
    logic       overflow;

    int   check_cnt;
    int   err_cnt;
    obs_t exp_q[$];

    pulse_stretch #(
        .HOLD_CYCLES(4),
        .GAP_CYCLES (2),
        .PEND_W     (2),
        .CNT_W      (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_pulse  (in_pulse),
        .retrig    (retrig),
        .clr_ovf   (clr_ovf),
        .out_level (out_level),
        .done      (done),
        .busy      (busy),
        .pend_count(pend_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input bit o, input bit d, input bit b, input logic [1:0] p, input bit v);
        return {o, d, b, p, v};
    endfunction

    function automatic obs_t sample();
        return {out_level, done, busy, pend_count, overflow};
    endfunction

    task automatic step(input bit p, input bit r, input bit c, input bit rs);
        in_pulse = p;
        retrig   = r;
        clr_ovf  = c;
        rst      = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, ex;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
            step(1'b1, 1'b0, 1'b0, i < 2);
            if (i == 2) begin
                // first non-reset edge with a pulse starts a hold
                ex = exp_q.pop_front();
                ex = mk(1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
            end else begin
                ex = exp_q.pop_front();
            end
            got = sample();
            check_cnt++;
            if (got !== ex) begin
                err_cnt++;
                $display("FAIL reset i=%0d got=%b exp=%b", i, got, ex);
            end
        end
        // let the started hold drain back to idle
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single();
        obs_t got, ex;
        for (int e = 10; e <= 17; e++) begin
            exp_q.push_back(mk(e >= 10 && e <= 13, e == 14, e >= 10 && e <= 15, 2'd0, 1'b0));
            step(e == 10, 1'b0, 1'b0, 1'b0);
            got = sample();
            ex  = exp_q.pop_front();
            check_cnt++;
            if (got !== ex) begin
                err_cnt++;
                $display("FAIL single e=%0d got=%b exp=%b", e, got, ex);
            end
        end
    endtask

    task automatic test_queue();
        obs_t got, ex;
        logic [1:0] p;
        for (int e = 10; e <= 29; e++) begin
            p = (e == 11) ? 2'd1 : (e >= 12 && e <= 15) ? 2'd2 : (e >= 16 && e <= 21) ? 2'd1 : 2'd0;
            exp_q.push_back(mk((e >= 10 && e <= 13) || (e >= 16 && e <= 19) || (e >= 22 && e <= 25),
                               e == 14 || e == 20 || e == 26, e >= 10 && e <= 27, p, 1'b0));
            step(e >= 10 && e <= 12, 1'b0, 1'b0, 1'b0);
            got = sample();
            ex  = exp_q.pop_front();
            check_cnt++;
            if (got !== ex) begin
                err_cnt++;
                $display("FAIL queue e=%0d got=%b exp=%b", e, got, ex);
            end
        end
    endtask

    task automatic test_overflow();
        obs_t got, ex;
        logic [1:0] p;
        for (int e = 10; e <= 35; e++) begin
            p = (e == 11) ? 2'd1 : (e == 12) ? 2'd2 : (e >= 13 && e <= 15) ? 2'd3 :
                (e >= 16 && e <= 21) ? 2'd2 : (e >= 22 && e <= 27) ? 2'd1 : 2'd0;
            exp_q.push_back(mk((e >= 10 && e <= 13) || (e >= 16 && e <= 19) ||
                               (e >= 22 && e <= 25) || (e >= 28 && e <= 31),
                               e == 14 || e == 20 || e == 26 || e == 32,
                               e >= 10 && e <= 33, p, e >= 14 && e <= 19));
            // edge 15: dropped pulse and clear together; edge 20: clear alone
            step(e >= 10 && e <= 15, 1'b0, e == 15 || e == 20, 1'b0);
            got = sample();
            ex  = exp_q.pop_front();
            check_cnt++;
            if (got !== ex) begin
                err_cnt++;
                $display("FAIL overflow e=%0d got=%b exp=%b", e, got, ex);
            end
        end
    endtask

    task automatic test_retrig();
        obs_t got, ex;
        for (int e = 10; e <= 19; e++) begin
            exp_q.push_back(mk(e >= 10 && e <= 15, e == 16, e >= 10 && e <= 17, 2'd0, 1'b0));
            step(e == 10 || e == 12, 1'b1, 1'b0, 1'b0);
            got = sample();
            ex  = exp_q.pop_front();
            check_cnt++;
            if (got !== ex) begin
                err_cnt++;
                $display("FAIL retrig e=%0d got=%b exp=%b", e, got, ex);
            end
        end
    endtask

    task automatic test_gap_coincide();
        obs_t got, ex;
        for (int e = 10; e <= 29; e++) begin
            exp_q.push_back(mk((e >= 10 && e <= 13) || (e >= 16 && e <= 19) || (e >= 22 && e <= 25),
                               e == 14 || e == 20 || e == 26, e >= 10 && e <= 27,
                               (e >= 11 && e <= 21) ? 2'd1 : 2'd0, 1'b0));
            step(e == 10 || e == 11 || e == 16, 1'b0, 1'b0, 1'b0);
            got = sample();
            ex  = exp_q.pop_front();
            check_cnt++;
            if (got !== ex) begin
                err_cnt++;
                $display("FAIL gap_coincide e=%0d got=%b exp=%b", e, got, ex);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        obs_t got, ex;
        for (int e = 10; e <= 21; e++) begin
            exp_q.push_back(mk(e == 10 || e == 11 || (e >= 14 && e <= 17), e == 18,
                               e == 10 || e == 11 || (e >= 14 && e <= 19), 2'd0, 1'b0));
            step(e == 10 || e == 12 || e == 14, 1'b0, 1'b0, e == 12);
            got = sample();
            ex  = exp_q.pop_front();
            check_cnt++;
            if (got !== ex) begin
                err_cnt++;
                $display("FAIL reset_mid_hold e=%0d got=%b exp=%b", e, got, ex);
            end
        end
    endtask

    initial begin
        check_cnt = 0;
        err_cnt   = 0;
        rst       = 1'b1;
        in_pulse  = 1'b0;
        retrig    = 1'b0;
        clr_ovf   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_queue();
        test_overflow();
        test_retrig();
        test_gap_coincide();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

endmodule
